// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: write-side front end for the async FIFO (wclk domain only).
// Packs RATIO narrow beats into one FIFO word and presents it through a
// single-word hold register that drives wdata/winc. s_last flushes a partial
// word. Lanes that were never written are zero.
module fifo_wr_packer #(
    parameter int IN_WIDTH  = 8,
    parameter int RATIO     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                        wclk,
    input  logic                        wrst_n,
    input  logic [IN_WIDTH-1:0]         s_data,
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic [IN_WIDTH*RATIO-1:0]   wdata,
    output logic                        winc,
    input  logic                        wfull,
    output logic [15:0]                 stall_cnt
);

    localparam int WORD_W = IN_WIDTH * RATIO;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic              hold_valid_q, hold_valid_d;
    logic [WORD_W-1:0] hold_word_q, hold_word_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic [WORD_W-1:0] merged_word;
    logic              hold_free;
    logic              completing;
    logic              accept;

    // The hold register can take a new word if it is empty or drains this cycle.
    assign hold_free  = !hold_valid_q || !wfull;
    assign completing = (lane_q == LAST_LANE) || s_last;
    // Only a completing beat needs room in the hold register.
    assign s_ready    = hold_free || !completing;
    assign accept     = s_valid && s_ready;

    // Accumulator with the incoming beat dropped into its lane. Since the
    // accumulator is cleared on every completion, later lanes are still zero.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            localparam int BEAT_IDX = (LSB_FIRST != 0) ? gi : (RATIO - 1 - gi);
            assign merged_word[gi*IN_WIDTH +: IN_WIDTH] =
                (lane_q == LANE_W'(BEAT_IDX)) ? s_data : acc_q[gi*IN_WIDTH +: IN_WIDTH];
        end
    endgenerate

    // Next-state: drain the hold on transfer, count stalls, take accepted beats.
    always_comb begin
        lane_d       = lane_q;
        acc_d        = acc_q;
        hold_valid_d = hold_valid_q;
        hold_word_d  = hold_word_q;
        stall_cnt_d  = stall_cnt_q;

        if (hold_valid_q && !wfull) begin
            hold_valid_d = 1'b0;
        end

        if (hold_valid_q && wfull && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        if (accept) begin
            if (completing) begin
                // A load in the same cycle as a transfer keeps the hold valid.
                hold_word_d  = merged_word;
                hold_valid_d = 1'b1;
                lane_d       = '0;
                acc_d        = '0;
            end else begin
                acc_d  = merged_word;
                lane_d = lane_q + LANE_W'(1);
            end
        end
    end

    // State registers; asynchronous reset discards any partial word.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            lane_q       <= '0;
            acc_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_word_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            lane_q       <= lane_d;
            acc_q        <= acc_d;
            hold_valid_q <= hold_valid_d;
            hold_word_q  <= hold_word_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign winc      = hold_valid_q;
    assign wdata     = hold_word_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Testbench for fifo_wr_packer: directed scenarios plus a randomized run,
// all checked against a beat-list reference model of the packer.
module tb_fifo_wr_packer;

    logic        wclk;
    logic        wrst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] wdata;
    logic        winc;
    logic        wfull;
    logic [15:0] stall_cnt;

    // second instance, MSB-first packing
    logic [7:0]  s2_data;
    logic        s2_valid;
    logic        s2_last;
    logic        s2_ready;
    logic [31:0] wdata2;
    logic        winc2;
    logic        wfull2;
    logic [15:0] stall_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [7:0]  beats[$];
    bit          m_occ;
    logic [31:0] m_word;
    int          m_stall;
    int          dut_xfer;

    fifo_wr_packer #(.IN_WIDTH(8), .RATIO(4), .LSB_FIRST(1)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready), .wdata(wdata), .winc(winc),
        .wfull(wfull), .stall_cnt(stall_cnt)
    );

    fifo_wr_packer #(.IN_WIDTH(8), .RATIO(4), .LSB_FIRST(0)) dut_msb (
        .wclk(wclk), .wrst_n(wrst_n), .s_data(s2_data), .s_valid(s2_valid),
        .s_last(s2_last), .s_ready(s2_ready), .wdata(wdata2), .winc(winc2),
        .wfull(wfull2), .stall_cnt(stall_cnt2)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // LSB-first word from a list of beats, unused lanes zero
    function automatic logic [31:0] pack(input logic [7:0] b[$]);
        logic [31:0] w;
        w = '0;
        foreach (b[i]) w[i*8 +: 8] = b[i];
        return w;
    endfunction

    task automatic model_reset();
        beats.delete();
        m_occ   = 1'b0;
        m_word  = '0;
        m_stall = 0;
    endtask

    // One clock cycle on the LSB-first instance. Entered at a falling edge.
    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit f);
        bit exp_ready;
        bit acc;
        s_valid = v;
        s_data  = d;
        s_last  = l;
        wfull   = f;
        exp_ready = !(m_occ && f) || !((beats.size() == 3) || l);
        #1;
        chk("s_ready", 32'(s_ready), 32'(exp_ready));
        chk("winc", 32'(winc), 32'(m_occ));
        if (m_occ) chk("wdata", wdata, m_word);
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        $display("t=%0t v=%0b d=%h l=%0b full=%0b ready=%0b winc=%0b wdata=%h stall=%0d",
                 $time, v, d, l, f, s_ready, winc, wdata, stall_cnt);
        if (winc && !f) dut_xfer++;
        @(posedge wclk);
        acc = v && exp_ready;
        if (m_occ && f && m_stall < 65535) m_stall++;
        if (m_occ && !f) m_occ = 1'b0;
        if (acc) begin
            beats.push_back(d);
            if (beats.size() == 4 || l) begin
                m_word = pack(beats);
                m_occ  = 1'b1;
                beats.delete();
            end
        end
        @(negedge wclk);
    endtask

    // Asynchronous reset pulse starting mid-cycle. Entered at a falling edge.
    task automatic do_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        wfull   = 1'b0;
        #2 wrst_n = 1'b0;
        #1;
        chk("rst_winc", 32'(winc), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        $display("t=%0t reset winc=%0b wdata=%h stall=%0d", $time, winc, wdata, stall_cnt);
        model_reset();
        @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    initial begin
        int x0;
        s_valid = 0; s_data = 0; s_last = 0; wfull = 0;
        s2_valid = 0; s2_data = 0; s2_last = 0; wfull2 = 0;
        wrst_n = 1'b0;
        dut_xfer = 0;
        model_reset();
        @(negedge wclk);
        @(negedge wclk);
        do_reset();

        // 1: four beats -> one full word
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h44, 0, 0);
        chk("t1_wdata", wdata, 32'h44332211);
        step(0, 8'h00, 0, 0);

        // 2: early flush, then a fresh word starting at lane 0
        step(1, 8'hAA, 0, 0);
        step(1, 8'hBB, 1, 0);
        chk("t2_flush", wdata, 32'h0000BBAA);
        step(1, 8'h01, 0, 0);
        step(1, 8'h02, 0, 0);
        step(1, 8'h03, 0, 0);
        step(1, 8'h04, 0, 0);
        chk("t2_next", wdata, 32'h04030201);
        step(0, 8'h00, 0, 0);

        // 4: 64 back-to-back beats -> 16 transfers
        x0 = dut_xfer;
        for (int i = 0; i < 64; i++) step(1, 8'(i + 8'h40), 0, 0);
        step(0, 8'h00, 0, 0);
        chk("t4_words", 32'(dut_xfer - x0), 32'd16);

        // 3: backpressure; stall count and ordering of held words
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 8'h11, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 8'h22, 0, 1);
        for (int i = 0; i < 7; i++) step(1, 8'h22, 0, 1);
        chk("t3_blocked", 32'(s_ready), 32'd0);
        chk("t3_stall", 32'(stall_cnt), 32'd10);
        chk("t3_word1", wdata, 32'h11111111);
        step(1, 8'h22, 0, 0);
        chk("t3_word2", wdata, 32'h22222222);
        step(0, 8'h00, 0, 0);

        // 5: reset in the middle of a word discards it
        step(1, 8'hDE, 0, 0);
        step(1, 8'hAD, 0, 0);
        do_reset();
        step(1, 8'h55, 0, 0);
        step(1, 8'h66, 0, 0);
        step(1, 8'h77, 0, 0);
        step(1, 8'h88, 0, 0);
        chk("t5_clean", wdata, 32'h88776655);
        step(0, 8'h00, 0, 0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
        end

        // 6: MSB-first instance and stall counter saturation
        s_valid = 0; wfull = 0;
        s2_valid = 1;
        s2_data = 8'h11; @(negedge wclk);
        s2_data = 8'h22; @(negedge wclk);
        s2_data = 8'h33; @(negedge wclk);
        s2_data = 8'h44; @(negedge wclk);
        s2_valid = 0;
        chk("t6_winc", 32'(winc2), 32'd1);
        chk("t6_wdata", wdata2, 32'h11223344);
        $display("t=%0t msb wdata=%h winc=%0b", $time, wdata2, winc2);
        wfull2 = 1;
        repeat (65540) @(negedge wclk);
        chk("t6_sat", 32'(stall_cnt2), 32'h0000FFFF);
        repeat (3) @(negedge wclk);
        chk("t6_sat_hold", 32'(stall_cnt2), 32'h0000FFFF);
        chk("t6_frozen", wdata2, 32'h11223344);
        $display("t=%0t msb stall=%h wdata=%h", $time, stall_cnt2, wdata2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
